// File: rtl/alu_pkg.sv
// Shared ALU-side types: branch condition encodings and the NZVC flag layout.
package alu_pkg;

    typedef enum logic [2:0] {
        COND_AL,
        COND_EQ,
        COND_NE,
        COND_LT,
        COND_GE,
        COND_CS,
        COND_CC,
        COND_MI
    } cond_t;

    typedef struct packed {
        logic n;
        logic z;
        logic v;
        logic c;
    } flags_t;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_V = 1;
    localparam int unsigned FLAG_C = 0;

endpackage

// File: rtl/alu_result_buffer_cond_eval.sv
// Combinational branch-condition evaluator over the NZVC status flags.
module cond_eval
    import alu_pkg::*;
(
    input  flags_t i_flags,
    input  cond_t  i_cond,
    output logic   o_cond_true
);

    always_comb begin
        o_cond_true = 1'b0;
        case (i_cond)
            COND_AL: o_cond_true = 1'b1;
            COND_EQ: o_cond_true = i_flags.z;
            COND_NE: o_cond_true = ~i_flags.z;
            COND_LT: o_cond_true = i_flags.n ^ i_flags.v;
            COND_GE: o_cond_true = ~(i_flags.n ^ i_flags.v);
            COND_CS: o_cond_true = i_flags.c;
            COND_CC: o_cond_true = ~i_flags.c;
            COND_MI: o_cond_true = i_flags.n;
            default: o_cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_result_buffer.sv
// 2-entry skid buffer for ALU results plus the NZVC status register and branch evaluation.
// Optional ALU_STICKY_OVERFLOW_EN adds a sticky overflow bit with sticky_clr/sticky_ov ports.
module alu_result_buffer
    import alu_pkg::*;
#(
    parameter int unsigned N     = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_result,
    input  logic         in_zero,
    input  logic         in_negative,
    input  logic         in_overflow,
    input  logic         in_carry,
    input  logic         in_flag_we,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_result,
    output logic [3:0]   flags,
`ifdef ALU_STICKY_OVERFLOW_EN
    input  logic         sticky_clr,
    output logic         sticky_ov,
`endif
    input  logic [2:0]   cond,
    output logic         cond_true
);

    localparam logic [1:0] FULL = 2'(DEPTH);

    logic [N-1:0] r_entry [0:1];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;
    flags_t       r_flags;

    logic         w_push;
    logic         w_pop;
    cond_t        w_cond;

    assign in_ready   = (r_count != FULL) & ~rst;
    assign out_valid  = (r_count != 2'd0);
    assign out_result = r_entry[r_rd_ptr];
    assign w_push     = in_valid & in_ready;
    assign w_pop      = out_valid & out_ready;
    assign flags      = r_flags;
    assign w_cond     = cond_t'(cond);

    // Only slot 0 is cleared: rd_ptr returns to 0, so that alone forces out_result to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count    <= '0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_flags    <= '0;
            r_entry[0] <= '0;
        end else begin
            if (w_push) begin
                r_entry[r_wr_ptr] <= in_result;
                r_wr_ptr          <= ~r_wr_ptr;
                if (in_flag_we) begin
                    r_flags <= '{n: in_negative, z: in_zero, v: in_overflow, c: in_carry};
                end
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef ALU_STICKY_OVERFLOW_EN
    logic r_sticky_ov;

    // Set takes priority over clear so an overflow in the clearing cycle is not lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sticky_ov <= 1'b0;
        end else if (w_push & in_overflow) begin
            r_sticky_ov <= 1'b1;
        end else if (sticky_clr) begin
            r_sticky_ov <= 1'b0;
        end
    end

    assign sticky_ov = r_sticky_ov;
`endif

    cond_eval u_cond_eval (
        .i_flags    (r_flags),
        .i_cond     (w_cond),
        .o_cond_true(cond_true)
    );

endmodule
